// File: rtl/run_ctrl_pkg.sv
// Shared encodings for the core run/step/halt controller.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_HALT = 2'd1,
    ST_RUN  = 2'd2,
    ST_STEP = 2'd3
  } run_state_e;

  typedef enum logic [1:0] {
    OP_RUN  = 2'd0,
    OP_HALT = 2'd1,
    OP_STEP = 2'd2,
    OP_CLR  = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    CAUSE_RESET = 2'd0,
    CAUSE_CMD   = 2'd1,
    CAUSE_BP    = 2'd2,
    CAUSE_CORE  = 2'd3
  } halt_cause_e;

  localparam int DEF_RESET_HOLD = 4;

endpackage

// File: rtl/run_ctrl_counters.sv
// Cycle and retired-instruction counters; a clear beats a same-cycle increment.
module run_ctrl_counters
  import run_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_cyc_inc,
  input  logic             i_ret_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cycle_cnt,
  output logic [CNT_W-1:0] o_retire_cnt
);

  logic [CNT_W-1:0] r_cyc;
  logic [CNT_W-1:0] r_ret;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_cyc <= '0;
      r_ret <= '0;
    end else if (i_clr) begin
      r_cyc <= '0;
      r_ret <= '0;
    end else begin
      if (i_cyc_inc) r_cyc <= r_cyc + CNT_W'(1);
      if (i_ret_inc) r_ret <= r_ret + CNT_W'(1);
    end
  end

  assign o_cycle_cnt  = r_cyc;
  assign o_retire_cnt = r_ret;

endmodule

// File: rtl/core_run_ctrl.sv
// Run/step/halt controller: reset sequencing, advance gating, breakpoints, counters.
// RUN_CTRL_AUTORUN_EN: when defined, HOLD exits straight to RUN instead of HALT.
module core_run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int PC_W       = 32,
  parameter int CNT_W      = 32,
  parameter int RESET_HOLD = DEF_RESET_HOLD
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [1:0]       i_cmd_op,
  input  logic             i_bp_en,
  input  logic [PC_W-1:0]  i_bp_addr,
  input  logic [PC_W-1:0]  i_core_pc,
  input  logic             i_core_halt_req,
  output logic             o_core_en,
  output logic             o_core_rst_n,
  output logic [1:0]       o_state,
  output logic [1:0]       o_halt_cause,
  output logic [CNT_W-1:0] o_cycle_cnt,
  output logic [CNT_W-1:0] o_retire_cnt
);

  localparam int HCW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(RESET_HOLD - 1);

  run_state_e       r_state, w_nxt_state;
  halt_cause_e      r_halt_cause, w_nxt_cause;
  logic             r_resume, w_nxt_resume;
  logic             r_cmd_ready;
  logic [HCW-1:0]   r_hold_cnt, w_nxt_hold;

  logic             w_accept, w_bp_hit, w_stop_bp, w_stop_req, w_clr;
  cmd_op_e          w_op;

  assign w_op     = cmd_op_e'(i_cmd_op);
  assign w_accept = i_cmd_valid & r_cmd_ready;
  assign w_bp_hit = i_bp_en & (i_core_pc == i_bp_addr);
  // The resume cycle masks stop sources so a halted core always makes progress.
  assign w_stop_bp  = w_bp_hit & ~r_resume;
  assign w_stop_req = i_core_halt_req & ~r_resume;
  assign w_clr      = w_accept & (w_op == OP_CLR);

  assign o_core_en = ((r_state == ST_RUN) & ~w_stop_bp & ~w_stop_req) |
                     (r_state == ST_STEP);
  assign o_core_rst_n = (r_state != ST_HOLD);

  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_cause  = r_halt_cause;
    w_nxt_resume = 1'b0;
    w_nxt_hold   = r_hold_cnt;
    case (r_state)
      ST_HOLD: begin
        if (r_hold_cnt == HOLD_LAST) begin
`ifdef RUN_CTRL_AUTORUN_EN
          w_nxt_state  = ST_RUN;
          w_nxt_resume = 1'b1;
`else
          w_nxt_state  = ST_HALT;
`endif
        end else begin
          w_nxt_hold = r_hold_cnt + HCW'(1);
        end
      end
      ST_HALT: begin
        if (w_accept) begin
          case (w_op)
            OP_RUN: begin
              w_nxt_state  = ST_RUN;
              w_nxt_resume = 1'b1;
            end
            OP_STEP: w_nxt_state = ST_STEP;
            OP_HALT: w_nxt_cause = CAUSE_CMD;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        if (w_stop_bp) begin
          w_nxt_state = ST_HALT;
          w_nxt_cause = CAUSE_BP;
        end else if (w_stop_req) begin
          w_nxt_state = ST_HALT;
          w_nxt_cause = CAUSE_CORE;
        end else if (w_accept && (w_op == OP_HALT)) begin
          w_nxt_state = ST_HALT;
          w_nxt_cause = CAUSE_CMD;
        end
      end
      ST_STEP: begin
        w_nxt_state = ST_HALT;
        w_nxt_cause = CAUSE_RESET;
      end
      default: w_nxt_state = ST_HOLD;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= ST_HOLD;
      r_halt_cause <= CAUSE_RESET;
      r_resume     <= 1'b0;
      r_cmd_ready  <= 1'b0;
      r_hold_cnt   <= '0;
    end else begin
      r_state      <= w_nxt_state;
      r_halt_cause <= w_nxt_cause;
      r_resume     <= w_nxt_resume;
      r_cmd_ready  <= (w_nxt_state == ST_HALT) | (w_nxt_state == ST_RUN);
      r_hold_cnt   <= w_nxt_hold;
    end
  end

  assign o_state      = r_state;
  assign o_halt_cause = r_halt_cause;
  assign o_cmd_ready  = r_cmd_ready;

  run_ctrl_counters #(.CNT_W(CNT_W)) u_cnt (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_cyc_inc    (o_core_rst_n),
    .i_ret_inc    (o_core_en),
    .i_clr        (w_clr),
    .o_cycle_cnt  (o_cycle_cnt),
    .o_retire_cnt (o_retire_cnt)
  );

endmodule

// File: doc/core_run_ctrl.md
Name: core_run_ctrl

Overview:
Run/step/halt controller for the single-cycle core (Top).
- Sequences the core's reset release.
- Gates instruction execution through an advance enable, so the core runs, single-steps, or halts on command, on a PC breakpoint, or on a core-raised halt request.
- Maintains cycle and retired-instruction counters.
- Sits between the debug/command interface and the core's PC/regfile write enables.

Parameters:
PC_W, 32, width of core PC and breakpoint address
CNT_W, 32, width of cycle_cnt and retire_cnt
RESET_HOLD, 4, clocks core_rst_n is held low after controller reset release (>=1)

Ports:
clock  in  1  sole clock, rising edge
reset  in  1  asynchronous active-low reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
cmd_op  in  2  0 RUN, 1 HALT, 2 STEP, 3 CLR (clear counters)
bp_en  in  1  breakpoint enable
bp_addr  in  PC_W  breakpoint PC
core_pc  in  PC_W  PC of instruction executing this cycle
core_halt_req  in  1  core requests halt on current instruction (ebreak/illegal)
core_en  out  1  core advance enable; 0 freezes PC and all state writes
core_rst_n  out  1  active-low reset to core
state  out  2  0 HOLD, 1 HALT, 2 RUN, 3 STEP
halt_cause  out  2  0 reset/step-done, 1 command, 2 breakpoint, 3 core request
cycle_cnt  out  CNT_W  cycles since core_rst_n high
retire_cnt  out  CNT_W  cycles with core_en=1

Behaviour:
Reset (reset=0, asynchronous):
- state=HOLD, core_rst_n=0 and core_en=0 immediately.
- cmd_ready=0, halt_cause=0, both counters 0.

HOLD:
- Hold counter runs RESET_HOLD clocks after reset deasserts.
- core_rst_n goes 1 on the same edge as the transition to HALT.
- cmd_ready=0.

HALT:
- core_en=0, cmd_ready=1.
- RUN -> RUN; sets a resume flag.
- STEP -> STEP.
- HALT -> stay HALT; halt_cause=1.
- CLR -> counters 0 next edge.

RUN:
- core_en = ~bp_hit & ~core_halt_req, combinational.
- bp_hit = bp_en & (core_pc==bp_addr).
- Resume-cycle rule: on the first RUN cycle after HALT, bp_hit and core_halt_req are masked, so exactly one instruction always executes.
- bp_hit -> HALT, cause=2. Else core_halt_req -> HALT, cause=3. Breakpoint has priority.
- cmd_ready=1.
  - HALT cmd: core_en unaffected this cycle; -> HALT next edge, cause=1. If bp_hit/core_halt_req occurs in the same cycle, that cause wins.
  - RUN and STEP cmds are accepted and ignored.
  - CLR clears counters.

STEP:
- Exactly one cycle with core_en=1; bp/halt_req ignored.
- -> HALT, cause=0.
- cmd_ready=0.

Counters:
- cycle_cnt += 1 every cycle core_rst_n=1.
- retire_cnt += 1 when core_en=1.
- Both wrap modulo 2^CNT_W silently.
- CLR in the same cycle as an increment: result 0 (clear wins).

Other rules:
- All outputs except core_en and core_rst_n are registered.
- halt_cause holds until the next halt event.
- Changing bp_addr during RUN takes effect the same cycle (combinational compare).

Optional Feature:
- Macro RUN_CTRL_AUTORUN_EN.
- Defined: HOLD exits directly to RUN with the resume flag set, so the core free-runs from reset with no command. Breakpoints and halt_req work as above.
- Undefined: HOLD exits to HALT and waits for a command.

Decomposition:
- Package run_ctrl_pkg: state encodings (HOLD/HALT/RUN/STEP), cmd_op encodings, halt_cause encodings, RESET_HOLD default.
- One natural sub-module, run_ctrl_counters: both CNT_W counters with increment/clear inputs and clear priority.
- FSM, breakpoint compare and handshake stay in core_run_ctrl.

Test Plan:
1. Reset low then high, RESET_HOLD=4 -> core_rst_n rises on 4th edge; state=HALT, core_en=0, retire_cnt=0, cycle_cnt counts from 0.
2. Three STEP commands, idle between -> exactly three 1-cycle core_en pulses; retire_cnt=3; halt_cause=0; cmd_ready=0 during each STEP cycle.
3. bp_en=1, bp_addr=0x10, RUN, core_pc 0x0,0x4,0x8,0xC,0x10 -> core_en=0 at 0x10, HALT, cause=2, retire_cnt=4. RUN again -> 0x10 executes, retire_cnt=5, continues.
4. RUN, core_halt_req=1 at core_pc=0x20 together with bp_addr=0x20, bp_en=1 -> core_en=0, HALT, cause=2. Repeat with bp_en=0 -> cause=3.
5. In RUN, HALT cmd at cycle N -> core_en=1 at N, 0 from N+1, cause=1. Then CLR while halted -> counters 0; CLR during RUN with core_en=1 -> retire_cnt=0, not 1.
6. Reset low mid-RUN -> core_en=0 and core_rst_n=0 before next edge; state=HOLD; counters 0. With RUN_CTRL_AUTORUN_EN, release -> RUN after 4 clocks, no command.
